// File: rtl/flg_encode.sv
// Sparsity encoder: packs the nonzero elements of each DEPTH-element channel block
// into a compressed data stream and emits one occupancy flag word per block.
module flg_encode #(
  parameter int DEPTH     = 32,
  parameter int ACT_WIDTH = 8,
  parameter int IDX_WIDTH = 5,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_clr,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [ACT_WIDTH-1:0] in_dat,
  input  logic                 in_last,
  output logic                 dat_vld,
  input  logic                 dat_rdy,
  output logic [ACT_WIDTH-1:0] dat_out,
  output logic [IDX_WIDTH-1:0] dat_idx,
  output logic                 flg_vld,
  input  logic                 flg_rdy,
  output logic [DEPTH-1:0]     flg_out,
  output logic [CNT_WIDTH-1:0] flg_nnz,
  output logic                 busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t               state_q,   state_d;
  logic [IDX_WIDTH-1:0] cnt_q,     cnt_d;
  logic [DEPTH-1:0]     acc_flg_q, acc_flg_d;
  logic [CNT_WIDTH-1:0] acc_nnz_q, acc_nnz_d;
  logic                 dat_vld_q, dat_vld_d;
  logic [ACT_WIDTH-1:0] dat_out_q, dat_out_d;
  logic [IDX_WIDTH-1:0] dat_idx_q, dat_idx_d;
  logic                 flg_vld_q, flg_vld_d;
  logic [DEPTH-1:0]     flg_out_q, flg_out_d;
  logic [CNT_WIDTH-1:0] flg_nnz_q, flg_nnz_d;
  logic                 busy_q,    busy_d;

  logic                 dat_space;
  logic                 flg_space;
  logic                 closing;
  logic                 in_rdy_c;
  logic                 accept;
  logic                 nz;
  logic [DEPTH-1:0]     elem_bit;
  logic [DEPTH-1:0]     flg_full;
  logic [CNT_WIDTH-1:0] nnz_full;

  // Stall whenever the element could need a slot that is not free, even for a zero
  // element, so acceptance never depends on the data value.
  always_comb begin
    dat_space = ~dat_vld_q | dat_rdy;
    flg_space = ~flg_vld_q | flg_rdy;
    closing   = (cnt_q == IDX_WIDTH'(DEPTH - 1)) | in_last;
    in_rdy_c  = rst_n & dat_space & (~closing | flg_space) & ~enc_clr;
    accept    = in_vld & in_rdy_c;
    nz        = |in_dat;
    elem_bit  = {{(DEPTH-1){1'b0}}, nz} << cnt_q;
    flg_full  = acc_flg_q | elem_bit;
    nnz_full  = acc_nnz_q + {{(CNT_WIDTH-1){1'b0}}, nz};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_flg_d = acc_flg_q;
    acc_nnz_d = acc_nnz_q;
    dat_vld_d = dat_vld_q;
    dat_out_d = dat_out_q;
    dat_idx_d = dat_idx_q;
    flg_vld_d = flg_vld_q;
    flg_out_d = flg_out_q;
    flg_nnz_d = flg_nnz_q;

    if (accept && nz) begin
      dat_vld_d = 1'b1;
      dat_out_d = in_dat;
      dat_idx_d = cnt_q;
    end else if (dat_rdy) begin
      dat_vld_d = 1'b0;
    end

    if (accept && closing) begin
      flg_vld_d = 1'b1;
      flg_out_d = flg_full;
      flg_nnz_d = nnz_full;
    end else if (flg_rdy) begin
      flg_vld_d = 1'b0;
    end

    // Abort drops only the partial block; output registers keep draining.
    if (enc_clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      acc_flg_d = '0;
      acc_nnz_d = '0;
    end else if (accept) begin
      if (closing) begin
        state_d   = IDLE;
        cnt_d     = '0;
        acc_flg_d = '0;
        acc_nnz_d = '0;
      end else begin
        state_d   = FILL;
        cnt_d     = cnt_q + 1'b1;
        acc_flg_d = flg_full;
        acc_nnz_d = nnz_full;
      end
    end

    busy_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_flg_q <= '0;
      acc_nnz_q <= '0;
      dat_vld_q <= 1'b0;
      dat_out_q <= '0;
      dat_idx_q <= '0;
      flg_vld_q <= 1'b0;
      flg_out_q <= '0;
      flg_nnz_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_flg_q <= acc_flg_d;
      acc_nnz_q <= acc_nnz_d;
      dat_vld_q <= dat_vld_d;
      dat_out_q <= dat_out_d;
      dat_idx_q <= dat_idx_d;
      flg_vld_q <= flg_vld_d;
      flg_out_q <= flg_out_d;
      flg_nnz_q <= flg_nnz_d;
      busy_q    <= busy_d;
    end
  end

  assign in_rdy  = in_rdy_c;
  assign dat_vld = dat_vld_q;
  assign dat_out = dat_out_q;
  assign dat_idx = dat_idx_q;
  assign flg_vld = flg_vld_q;
  assign flg_out = flg_out_q;
  assign flg_nnz = flg_nnz_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_flg_encode.sv
// Bench for flg_encode: queue-based block model checked every cycle, directed
// block patterns with literal expectations, then randomized traffic.
module tb_flg_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_clr;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  in_dat;
  logic        in_last;
  logic        dat_vld;
  logic        dat_rdy;
  logic [7:0]  dat_out;
  logic [4:0]  dat_idx;
  logic        flg_vld;
  logic        flg_rdy;
  logic [31:0] flg_out;
  logic [5:0]  flg_nnz;
  logic        busy;

  flg_encode #(.DEPTH(32), .ACT_WIDTH(8), .IDX_WIDTH(5), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .enc_clr(enc_clr),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_last(in_last),
    .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat_out(dat_out), .dat_idx(dat_idx),
    .flg_vld(flg_vld), .flg_rdy(flg_rdy), .flg_out(flg_out), .flg_nnz(flg_nnz),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by main
  int stall_cnt = 0;
  int last_acc_cyc = 0;

  // Behavioural model: position in block, bitmap so far, pending output queues.
  int          pos = 0;
  logic [31:0] bm = '0;
  logic [7:0]  dq_val[$];
  int          dq_idx[$];
  logic [31:0] fq_bm[$];
  int          fq_nnz[$];

  // Everything the DUT actually delivered, for literal checks.
  logic [7:0]  cap_val[$];
  int          cap_idx[$];
  int          cap_dcyc[$];
  logic [31:0] cap_flg[$];
  int          cap_nnz[$];
  int          cap_fcyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      dat_rdy = ($urandom_range(0, 3) != 0);
      flg_rdy = ($urandom_range(0, 2) != 0);
    end else if (rdy_mode == 0) begin
      dat_rdy = 1'b1;
      flg_rdy = 1'b1;
    end
  end

  // Compare process: outputs vs model every cycle, then advance the model with the
  // transfers that the coming clock edge will perform.
  initial forever begin
    logic closing_m;
    logic exp_rdy;
    int   nz_cnt;
    @(negedge clk);
    if (!rst_n) begin
      pos = 0;
      bm = '0;
      dq_val.delete(); dq_idx.delete(); fq_bm.delete(); fq_nnz.delete();
      check("rst_in_rdy", in_rdy, 0);
      check("rst_dat_vld", dat_vld, 0);
      check("rst_flg_vld", flg_vld, 0);
      check("rst_outs", {dat_out, dat_idx, flg_out, flg_nnz, busy}, 0);
    end else begin
      check("dat_vld", dat_vld, dq_val.size() != 0);
      if (dq_val.size() != 0 && dat_vld) begin
        check("dat_out", dat_out, dq_val[0]);
        check("dat_idx", dat_idx, dq_idx[0]);
      end
      check("flg_vld", flg_vld, fq_bm.size() != 0);
      if (fq_bm.size() != 0 && flg_vld) begin
        check("flg_out", flg_out, fq_bm[0]);
        check("flg_nnz", flg_nnz, fq_nnz[0]);
      end
      check("busy", busy, pos != 0);
      closing_m = (pos == 31) || in_last;
      exp_rdy = ((dq_val.size() == 0) || dat_rdy) &&
                (!closing_m || (fq_bm.size() == 0) || flg_rdy) && !enc_clr;
      check("in_rdy", in_rdy, exp_rdy);

      if (dat_vld && dat_rdy) begin
        cap_val.push_back(dat_out); cap_idx.push_back(int'(dat_idx)); cap_dcyc.push_back(cyc);
        if (dq_val.size() != 0) begin
          void'(dq_val.pop_front()); void'(dq_idx.pop_front());
        end
      end
      if (flg_vld && flg_rdy) begin
        cap_flg.push_back(flg_out); cap_nnz.push_back(int'(flg_nnz)); cap_fcyc.push_back(cyc);
        if (fq_bm.size() != 0) begin
          void'(fq_bm.pop_front()); void'(fq_nnz.pop_front());
        end
      end
      if (enc_clr) begin
        pos = 0;
        bm = '0;
      end else if (in_vld && in_rdy) begin
        last_acc_cyc = cyc;
        if (in_dat != 0) begin
          dq_val.push_back(in_dat);
          dq_idx.push_back(pos);
          bm[pos] = 1'b1;
        end
        if (closing_m) begin
          nz_cnt = $countones(bm);
          fq_bm.push_back(bm);
          fq_nnz.push_back(nz_cnt);
          pos = 0;
          bm = '0;
        end else begin
          pos++;
        end
      end
    end
  end

  // Called and returns at posedge+1; holds the element until it is accepted.
  task automatic send(input logic [7:0] v, input logic last);
    int n;
    n = 0;
    in_vld = 1'b1; in_dat = v; in_last = last;
    @(negedge clk);
    while (!in_rdy) begin
      n++;
      stall_cnt++;
      if (n > 300) begin
        check("send_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_vld = 1'b0; in_dat = '0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((dq_val.size() != 0 || fq_bm.size() != 0 || dat_vld || flg_vld) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("drain_dat_q", dq_val.size(), 0);
    check("drain_flg_q", fq_bm.size(), 0);
  endtask

  task automatic clear_caps();
    cap_val.delete(); cap_idx.delete(); cap_dcyc.delete();
    cap_flg.delete(); cap_nnz.delete(); cap_fcyc.delete();
  endtask

  task automatic pulse_clr();
    enc_clr = 1'b1;
    @(posedge clk); #1;
    enc_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    logic [7:0] v;
    rst_n = 1'b1; enc_clr = 1'b0; in_vld = 1'b0; in_dat = '0; in_last = 1'b0;
    dat_rdy = 1'b1; flg_rdy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_rdy", in_rdy, 0);
    check("reset_outputs", {dat_vld, flg_vld, dat_out, dat_idx, flg_out, flg_nnz, busy}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Dense block 1..32
    clear_caps(); stall_cnt = 0;
    for (int i = 0; i < 32; i++) send(8'(i + 1), 1'b0);
    drain();
    check("dense_stalls", stall_cnt, 0);
    check("dense_beats", cap_val.size(), 32);
    ok = 1;
    for (int i = 0; i < cap_idx.size(); i++)
      if (cap_idx[i] != i || cap_val[i] != 8'(i + 1)) ok = 0;
    check("dense_beat_order", ok, 1);
    check("dense_nflg", cap_flg.size(), 1);
    if (cap_flg.size() == 1 && cap_val.size() == 32) begin
      check("dense_flg", cap_flg[0], 32'hFFFF_FFFF);
      check("dense_nnz", cap_nnz[0], 32);
      check("dense_same_cycle", cap_fcyc[0], cap_dcyc[31]);
    end

    // All-zero block
    clear_caps();
    for (int i = 0; i < 32; i++) send(8'h00, 1'b0);
    drain();
    check("zero_beats", cap_val.size(), 0);
    check("zero_nflg", cap_flg.size(), 1);
    if (cap_flg.size() == 1) begin
      check("zero_flg", cap_flg[0], 32'h0);
      check("zero_nnz", cap_nnz[0], 0);
      check("zero_flg_latency", cap_fcyc[0], last_acc_cyc + 1);
    end

    // Sparse block
    clear_caps();
    for (int i = 0; i < 32; i++)
      send((i == 0) ? 8'h11 : (i == 5) ? 8'h22 : (i == 31) ? 8'h33 : 8'h00, 1'b0);
    drain();
    check("sparse_beats", cap_val.size(), 3);
    if (cap_val.size() == 3) begin
      check("sparse_b0", {cap_val[0], 8'(cap_idx[0])}, 16'h1100);
      check("sparse_b1", {cap_val[1], 8'(cap_idx[1])}, 16'h2205);
      check("sparse_b2", {cap_val[2], 8'(cap_idx[2])}, 16'h331F);
    end
    check("sparse_nflg", cap_flg.size(), 1);
    if (cap_flg.size() == 1) begin
      check("sparse_flg", cap_flg[0], 32'h8000_0021);
      check("sparse_nnz", cap_nnz[0], 3);
    end

    // Early close on element 9
    clear_caps();
    for (int i = 0; i < 9; i++) send(8'h00, 1'b0);
    send(8'h7F, 1'b1);
    drain();
    check("early_nflg", cap_flg.size(), 1);
    if (cap_flg.size() == 1) begin
      check("early_flg", cap_flg[0], 32'h0000_0200);
      check("early_nnz", cap_nnz[0], 1);
    end

    // Next block starts at idx 0, then abort after 10 elements
    clear_caps();
    send(8'h55, 1'b0);
    for (int i = 1; i < 10; i++) send((i % 3 == 0) ? 8'(i) : 8'h00, 1'b0);
    pulse_clr();
    drain();
    check("abort_first_idx", (cap_idx.size() > 0) ? cap_idx[0] : -1, 0);
    check("abort_first_val", (cap_val.size() > 0) ? cap_val[0] : 8'h00, 8'h55);
    check("abort_no_flag", cap_flg.size(), 0);
    check("abort_busy", busy, 0);
    clear_caps();
    send(8'h00, 1'b0); send(8'h44, 1'b0); send(8'h00, 1'b1);
    drain();
    check("post_abort_beat", (cap_val.size() == 1) ? {cap_val[0], 8'(cap_idx[0])} : 16'hFFFF, 16'h4401);
    check("post_abort_flg", (cap_flg.size() == 1) ? cap_flg[0] : 32'hDEAD_BEEF, 32'h0000_0002);

    // Flag back-pressure across two blocks
    rdy_mode = 2; dat_rdy = 1'b1; flg_rdy = 1'b0;
    for (int i = 0; i < 32; i++) send(8'(i + 1), 1'b0);
    for (int i = 0; i < 31; i++) send((i % 2) ? 8'(i) : 8'h00, 1'b0);
    in_vld = 1'b1; in_dat = 8'd31; in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_rdy_low", in_rdy, 0);
      check("bp_flg_held", {flg_vld, flg_out, flg_nnz}, {1'b1, 32'hFFFF_FFFF, 6'd32});
    end
    @(posedge clk); #1;
    flg_rdy = 1'b1;
    @(negedge clk);
    check("bp_accept", in_rdy, 1);
    @(posedge clk); #1;
    flg_rdy = 1'b0; in_vld = 1'b0; in_dat = '0;
    @(negedge clk);
    check("bp_blk2_flg", {flg_vld, flg_out, flg_nnz}, {1'b1, 32'hAAAA_AAAA, 6'd16});
    @(posedge clk); #1;
    flg_rdy = 1'b1;
    drain();

    // Data back-pressure: even a zero element stalls
    dat_rdy = 1'b0;
    in_vld = 1'b1; in_dat = 8'h5A;
    @(negedge clk);
    check("dbp_first_accept", in_rdy, 1);
    @(posedge clk); #1;
    in_dat = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("dbp_stall", in_rdy, 0);
    end
    @(posedge clk); #1;
    dat_rdy = 1'b1;
    @(negedge clk);
    check("dbp_resume", in_rdy, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    drain();

    // Async reset with both outputs pending
    dat_rdy = 1'b0; flg_rdy = 1'b0;
    send(8'h66, 1'b1);
    check("pre_rst_pending", {dat_vld, flg_vld}, 2'b11);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {dat_vld, flg_vld, dat_out, dat_idx, flg_out, flg_nnz, busy}, 0);
    check("async_rst_in_rdy", in_rdy, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    dat_rdy = 1'b1; flg_rdy = 1'b1; rdy_mode = 0;
    @(posedge clk); #1;
    clear_caps();
    for (int i = 0; i < 32; i++)
      send((i == 0) ? 8'h11 : (i == 5) ? 8'h22 : (i == 31) ? 8'h33 : 8'h00, 1'b0);
    drain();
    check("post_rst_nbeats", cap_val.size(), 3);
    check("post_rst_flg", (cap_flg.size() == 1) ? cap_flg[0] : 32'hDEAD_BEEF, 32'h8000_0021);

    // Randomized traffic
    rdy_mode = 1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 40) == 0) pulse_clr();
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      v = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
      send(v, $urandom_range(0, 15) == 0);
    end
    pulse_clr();
    rdy_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flg_encode.md
Name: flg_encode

Overview:
- Sparsity encoder; the write side of the flag/offset addressing scheme used by the PE MAC flag-offset logic.
- Consumes a dense, serial stream of activation values grouped into channel blocks of DEPTH elements.
- Emits only the nonzero values on a compressed data stream, plus one DEPTH-bit occupancy flag word per block.
- Sits between the PE output/ReLU stage and the compressed activation buffer. Its flag words and packed data are the inputs later consumed as PECMAC_FlgAct and the compressed activation array.

Parameters:
- DEPTH, 32: elements per block; width of the flag word.
- ACT_WIDTH, 8: width of one activation value.
- IDX_WIDTH, 5: element index width, equal to log2(DEPTH).
- CNT_WIDTH, 6: nonzero-count width, equal to log2(DEPTH)+1 so that a count of DEPTH is representable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enc_clr  in  1  synchronous abort of the partial block.
- in_vld  in  1  dense input valid.
- in_rdy  out  1  dense input ready.
- in_dat  in  ACT_WIDTH  dense activation value.
- in_last  in  1  closes the block early with this element.
- dat_vld  out  1  compressed data valid.
- dat_rdy  in  1  compressed data ready.
- dat_out  out  ACT_WIDTH  nonzero value.
- dat_idx  out  IDX_WIDTH  position of dat_out within its block.
- flg_vld  out  1  flag word valid.
- flg_rdy  in  1  flag word ready.
- flg_out  out  DEPTH  occupancy bitmap; bit i = element i nonzero; bit 0 = first element.
- flg_nnz  out  CNT_WIDTH  popcount of flg_out.
- busy  out  1  high when state is FILL.

Behaviour:
- Reset values: in_rdy=0 during reset; dat_vld=0, dat_out=0, dat_idx=0, flg_vld=0, flg_out=0, flg_nnz=0, busy=0. Internal: state=IDLE, cnt=0, flag accumulator=0, nnz accumulator=0.
- Handshakes are valid/ready; a transfer occurs on a clk edge with vld&rdy. Once vld is asserted, the producer holds data stable until the transfer.
- Slot availability:
  - dat_space = ~dat_vld | dat_rdy.
  - flg_space = ~flg_vld | flg_rdy.
- Input acceptance: in_rdy = dat_space & (~closing | flg_space) & ~enc_clr, where closing = (cnt==DEPTH-1) | in_last.
  - Conservative rule: a stall occurs even when the element is zero.
- Zero test: an element is zero iff all ACT_WIDTH bits are 0.
- On accept of a nonzero element (1-cycle latency):
  - Next cycle dat_vld=1, dat_out=in_dat, dat_idx=cnt.
  - Flag accumulator bit[cnt] is set; nnz accumulator increments.
- On accept of a zero element: no data beat is produced; cnt still advances.
- dat_vld clears on dat_rdy unless a new nonzero element is accepted in the same cycle.
- Block close (accepted element with closing=1):
  - flg_out = accumulator including the current element's bit; flg_nnz = final count; flg_vld=1 next cycle.
  - Bits above the closing element are 0.
  - cnt, accumulators return to 0; state -> IDLE.
  - Data beat and flag word of the last element become valid in the same cycle.
- flg_vld clears on flg_rdy unless a new block closes in the same cycle; a same-cycle close loads the new word.
- FSM:
  - IDLE -> FILL on an accepted non-closing element.
  - FILL -> IDLE on an accepted closing element.
  - Any state -> IDLE on enc_clr.
  - IDLE with an accepted closing element (single-element block) stays IDLE and emits the flag.
- cnt wraps DEPTH-1 -> 0 only through close; it never exceeds DEPTH-1.
- enc_clr:
  - Discards the partial block (cnt, accumulators cleared; no flag emitted); in_rdy=0 that cycle.
  - Already-valid dat/flg output registers are unaffected and still drain.
  - Data beats of the aborted block already issued are not recalled; the downstream uses enc_clr to rewind its own write pointer.
- Async reset mid-operation: immediately returns everything to reset values; partial blocks and pending outputs are lost.
- Data stream and flag stream are independent. Data beats of block N may drain before or after flag N; ordering within each stream is strict.

Test Plan:
- Dense block: 32 elements 1..32, dat_rdy=flg_rdy=1. Expect 32 beats with dat_idx 0..31, flg_out=0xFFFFFFFF, flg_nnz=32, and no input stall.
- All-zero block: 32 zeros. Expect no dat_vld pulses, flg_out=0x00000000, flg_nnz=0, one flg_vld pulse one cycle after element 31.
- Sparse block: nonzero only at elements 0, 5, 31 (values 0x11, 0x22, 0x33). Expect beats (0x11,0), (0x22,5), (0x33,31), flg_out=0x80000021, flg_nnz=3.
- Early close: in_last on element 9 (value 0x7F), elements 0–8 zero. Expect flg_out=0x00000200, flg_nnz=1; the next element lands at dat_idx 0 of a new block.
- Back-pressure: flg_rdy=0 across two consecutive dense blocks.
  - in_rdy stays low while element 31 of block 2 is presented; block 1 word is held stable.
  - After flg_rdy=1 for one cycle, block 2 element 31 is accepted; block 2 word follows.
  - With dat_rdy=0, in_rdy is low and no element is lost.
- Abort and reset:
  - enc_clr after 10 elements: no flag emitted; the next block starts at idx 0.
  - rst_n low mid-block with dat_vld=flg_vld=1: all outputs read 0 asynchronously; the first post-reset block is encoded correctly.
